// File: rtl/pic_host_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared types and constants for the PIC host sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_SETUP = 4'd1,
        ST_WR_PULSE = 4'd2,
        ST_WR_HOLD  = 4'd3,
        ST_RD_PULSE = 4'd4,
        ST_RD_DONE  = 4'd5,
        ST_INTA1    = 4'd6,
        ST_INTA_GAP = 4'd7,
        ST_INTA2    = 4'd8,
        ST_VEC_DONE = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        W_ICW1 = 2'd0,
        W_ICW2 = 2'd1,
        W_ICW3 = 2'd2,
        W_ICW4 = 2'd3
    } icw_idx_t;

    typedef struct packed {
        logic     more;
        icw_idx_t idx;
    } icw_next_t;

    localparam logic A0_CMD  = 1'b0;
    localparam logic A0_DATA = 1'b1;

    localparam int IC4     = 0;
    localparam int SNGL    = 1;
    localparam int LTIM    = 3;
    localparam int ICW1_ID = 4;

    // Picks the init word that follows cur; ICW3 only in cascade mode, ICW4 only when requested.
    function automatic icw_next_t next_icw(input icw_idx_t cur, input logic sngl, input logic ic4);
        icw_next_t n;
        n.more = 1'b0;
        n.idx  = W_ICW1;
        case (cur)
            W_ICW1: begin
                n.more = 1'b1;
                n.idx  = W_ICW2;
            end
            W_ICW2: begin
                if (!sngl) begin
                    n.more = 1'b1;
                    n.idx  = W_ICW3;
                end else if (ic4) begin
                    n.more = 1'b1;
                    n.idx  = W_ICW4;
                end
            end
            W_ICW3: begin
                if (ic4) begin
                    n.more = 1'b1;
                    n.idx  = W_ICW4;
                end
            end
            default: n.more = 1'b0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_host_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_host_sequencer_if
// Description : Register-port and INTA bus between host sequencer and PIC.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_host_sequencer_if;
    logic       wr_enable;
    logic       rd_enable;
    logic       a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       inta_n;
    logic       int_in;

    modport master (
        output wr_enable, rd_enable, a0, data_out, data_oe, inta_n,
        input  data_in, int_in
    );

    modport slave (
        input  wr_enable, rd_enable, a0, data_out, data_oe, inta_n,
        output data_in, int_in
    );
endinterface
`default_nettype wire

// File: rtl/pic_host_sequencer_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module      : pic_strobe_timer
// Description : Load/count-down timer; done marks the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_strobe_timer #(
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    output logic                  done
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cur;

    // The load cycle is itself the first counted cycle of the phase.
    assign w_cur = load ? load_val : r_cnt;
    assign done  = (w_cur == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= (w_cur != '0) ? (w_cur - CNT_W'(1)) : '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pic_host_sequencer
// Description : CPU-side initiator: ICW init, OCW writes, reads, INTA cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_host_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       init_start,
    input  wire logic [7:0] icw1,
    input  wire logic [7:0] icw2,
    input  wire logic [7:0] icw3,
    input  wire logic [7:0] icw4,
    input  wire logic       ocw_req,
    input  wire logic       ocw_a0,
    input  wire logic [7:0] ocw_data,
    input  wire logic       rd_req,
    input  wire logic       rd_a0,
    output logic      [7:0] rd_data,
    output logic            rd_valid,
    output logic      [7:0] vector,
    output logic            vector_valid,
    output logic            initialized,
    output logic            busy,
    pic_host_sequencer_if.master bus
);
    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(GAP_CYC);

    state_t           r_state;
    logic             r_wr_enable, r_rd_enable, r_inta_n, r_a0, r_data_oe;
    logic [7:0]       r_data_out, r_rd_data, r_vector;
    logic             r_rd_valid, r_vector_valid, r_initialized, r_busy;
    logic             r_in_init, r_init_gap, r_sngl, r_ic4;
    icw_idx_t         r_word;
    logic [7:0]       r_icw2, r_icw3, r_icw4;
    logic             r_tmr_load;
    logic [CNT_W-1:0] r_tmr_val;
    logic             w_tmr_done;
    icw_next_t        w_next;

    assign w_next = next_icw(r_word, r_sngl, r_ic4);

    pic_strobe_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (r_tmr_load),
        .load_val (r_tmr_val),
        .done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_wr_enable    <= 1'b0;
            r_rd_enable    <= 1'b0;
            r_inta_n       <= 1'b1;
            r_a0           <= 1'b0;
            r_data_oe      <= 1'b0;
            r_data_out     <= 8'h00;
            r_rd_data      <= 8'h00;
            r_vector       <= 8'h00;
            r_rd_valid     <= 1'b0;
            r_vector_valid <= 1'b0;
            r_initialized  <= 1'b0;
            r_busy         <= 1'b0;
            r_in_init      <= 1'b0;
            r_init_gap     <= 1'b0;
            r_sngl         <= 1'b0;
            r_ic4          <= 1'b0;
            r_word         <= W_ICW1;
            r_icw2         <= 8'h00;
            r_icw3         <= 8'h00;
            r_icw4         <= 8'h00;
            r_tmr_load     <= 1'b0;
            r_tmr_val      <= '0;
        end else begin
            r_tmr_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_init_gap) begin
                        // Inter-word gap of the init sequence: no arbitration here.
                        r_init_gap <= 1'b0;
                        r_state    <= ST_WR_SETUP;
                        r_busy     <= 1'b1;
                        r_data_oe  <= 1'b1;
                        r_a0       <= A0_DATA;
                        case (r_word)
                            W_ICW2:  r_data_out <= r_icw2;
                            W_ICW3:  r_data_out <= r_icw3;
                            default: r_data_out <= r_icw4;
                        endcase
                    end else if (bus.int_in && r_initialized) begin
                        r_state    <= ST_INTA1;
                        r_busy     <= 1'b1;
                        r_inta_n   <= 1'b0;
                        r_tmr_load <= 1'b1;
                        r_tmr_val  <= C_PULSE;
                    end else if (init_start) begin
                        r_state       <= ST_WR_SETUP;
                        r_busy        <= 1'b1;
                        r_initialized <= 1'b0;
                        r_in_init     <= 1'b1;
                        r_word        <= W_ICW1;
                        r_sngl        <= icw1[SNGL];
                        r_ic4         <= icw1[IC4];
                        r_icw2        <= icw2;
                        r_icw3        <= icw3;
                        r_icw4        <= icw4;
                        r_data_oe     <= 1'b1;
                        r_a0          <= A0_CMD;
                        r_data_out    <= icw1;
                    end else if (ocw_req && r_initialized) begin
                        r_state    <= ST_WR_SETUP;
                        r_busy     <= 1'b1;
                        r_data_oe  <= 1'b1;
                        r_a0       <= ocw_a0;
                        r_data_out <= ocw_data;
                    end else if (rd_req && r_initialized) begin
                        r_state     <= ST_RD_PULSE;
                        r_busy      <= 1'b1;
                        r_rd_enable <= 1'b1;
                        r_a0        <= rd_a0;
                        r_tmr_load  <= 1'b1;
                        r_tmr_val   <= C_PULSE;
                    end
                end
                ST_WR_SETUP: begin
                    r_state     <= ST_WR_PULSE;
                    r_wr_enable <= 1'b1;
                    r_tmr_load  <= 1'b1;
                    r_tmr_val   <= C_PULSE;
                end
                ST_WR_PULSE: begin
                    if (w_tmr_done) begin
                        r_state     <= ST_WR_HOLD;
                        r_wr_enable <= 1'b0;
                    end
                end
                ST_WR_HOLD: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (r_in_init) begin
                        if (w_next.more) begin
                            r_word     <= w_next.idx;
                            r_init_gap <= 1'b1;
                        end else begin
                            r_in_init     <= 1'b0;
                            r_initialized <= 1'b1;
                        end
                    end
                end
                ST_RD_PULSE: begin
                    if (w_tmr_done) begin
                        r_state     <= ST_RD_DONE;
                        r_rd_enable <= 1'b0;
                        r_rd_data   <= bus.data_in;
                        r_rd_valid  <= 1'b1;
                    end
                end
                ST_RD_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_rd_valid <= 1'b0;
                end
                ST_INTA1: begin
                    if (w_tmr_done) begin
                        r_state    <= ST_INTA_GAP;
                        r_inta_n   <= 1'b1;
                        r_tmr_load <= 1'b1;
                        r_tmr_val  <= C_GAP;
                    end
                end
                ST_INTA_GAP: begin
                    if (w_tmr_done) begin
                        r_state    <= ST_INTA2;
                        r_inta_n   <= 1'b0;
                        r_tmr_load <= 1'b1;
                        r_tmr_val  <= C_PULSE;
                    end
                end
                ST_INTA2: begin
                    if (w_tmr_done) begin
                        r_state        <= ST_VEC_DONE;
                        r_inta_n       <= 1'b1;
                        r_vector       <= bus.data_in;
                        r_vector_valid <= 1'b1;
                    end
                end
                ST_VEC_DONE: begin
                    r_state        <= ST_IDLE;
                    r_busy         <= 1'b0;
                    r_vector_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_enable = r_wr_enable;
    assign bus.rd_enable = r_rd_enable;
    assign bus.inta_n    = r_inta_n;
    assign bus.a0        = r_a0;
    assign bus.data_out  = r_data_out;
    assign bus.data_oe   = r_data_oe;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign vector        = r_vector;
    assign vector_valid  = r_vector_valid;
    assign initialized   = r_initialized;
    assign busy          = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_host_sequencer
// Description : Table-driven, scoreboarded bench for pic_host_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_host_sequencer;
    localparam int P = 2;
    localparam int G = 1;
    localparam int K_INIT = 0;
    localparam int K_OCW  = 1;
    localparam int K_RD   = 2;
    localparam int K_INTA = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
    logic       ocw_req = 1'b0, ocw_a0 = 1'b0, rd_req = 1'b0, rd_a0 = 1'b0;
    logic [7:0] ocw_data = 8'h00;
    logic [7:0] rd_data, vector;
    logic       rd_valid, vector_valid, initialized, busy;

    always #5 clk = ~clk;

    pic_host_sequencer_if bus();

    pic_host_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_start   (init_start),
        .icw1         (icw1),
        .icw2         (icw2),
        .icw3         (icw3),
        .icw4         (icw4),
        .ocw_req      (ocw_req),
        .ocw_a0       (ocw_a0),
        .ocw_data     (ocw_data),
        .rd_req       (rd_req),
        .rd_a0        (rd_a0),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .vector       (vector),
        .vector_valid (vector_valid),
        .initialized  (initialized),
        .busy         (busy),
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Controller model: returns rd_val on reads, 0xEE on the first INTA, vec_val on the second.
    logic [7:0] rd_val = 8'h00;
    logic [7:0] vec_val = 8'h00;
    int         inta_falls = 0;
    bit         auto_drop = 1'b0;

    assign bus.data_in = bus.rd_enable ? rd_val :
                         (!bus.inta_n ? ((inta_falls % 2 == 0) ? vec_val : 8'hEE) : 8'h00);

    always @(negedge bus.inta_n) begin
        if (rst_n) begin
            inta_falls++;
            if (inta_falls % 2 == 0 && auto_drop) bus.int_in = 1'b0;
        end
    end

    typedef struct packed {
        logic       a0;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_vec[$];
    int         n_wr = 0, n_rd = 0, n_vec = 0;
    logic       prev_wr = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_enable && !prev_wr) begin
                n_wr++;
                check("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_a0", bus.a0, e.a0);
                    check("wr_data", bus.data_out, e.d);
                    check("wr_oe", bus.data_oe, 1);
                end
            end
            prev_wr = bus.wr_enable;
            if (rd_valid) begin
                n_rd++;
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (vector_valid) begin
                n_vec++;
                check("vec_expected", exp_vec.size() != 0, 1);
                if (exp_vec.size() != 0) check("vector", vector, exp_vec.pop_front());
            end
            if (int'(bus.wr_enable) + int'(bus.rd_enable) + int'(!bus.inta_n) > 1)
                check("strobe_exclusive", int'(bus.wr_enable) + int'(bus.rd_enable) + int'(!bus.inta_n), 1);
        end else begin
            prev_wr = 1'b0;
        end
    end

    typedef struct {
        int         kind;
        logic [7:0] w1, w2, w3, w4;
        logic       a0;
        logic [7:0] d;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        init_start = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
        bus.int_in = 1'b0; auto_drop = 1'b0; inta_falls = 0;
        exp_wr.delete(); exp_rd.delete(); exp_vec.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   wr0, rd0, vec0, busy_cnt;
        logic prev_b, done;
        logic [15:0] trace, exp_trace;
        wr0 = n_wr; rd0 = n_rd; vec0 = n_vec;
        case (v.kind)
            K_INIT: begin
                @(negedge clk);
                init_start = 1'b1; icw1 = v.w1; icw2 = v.w2; icw3 = v.w3; icw4 = v.w4;
                exp_wr.push_back({1'b0, v.w1});
                exp_wr.push_back({1'b1, v.w2});
                if (!v.w1[1]) exp_wr.push_back({1'b1, v.w3});
                if (v.w1[0])  exp_wr.push_back({1'b1, v.w4});
                @(negedge clk);
                init_start = 1'b0;
                check("init_clears_initialized", initialized, 0);
                busy_cnt = 0; prev_b = 1'b0; done = 1'b0;
                for (int c = 0; c < 200; c++) begin
                    if (initialized) begin
                        done = 1'b1;
                        break;
                    end
                    busy_cnt += int'(busy);
                    prev_b = busy;
                    @(negedge clk);
                end
                check("init_done", done, 1);
                check("init_busy_cycles", busy_cnt, v.exp_cnt * (2 + P));
                check("init_set_after_last_hold", prev_b, 1);
                check("init_idle_when_set", busy, 0);
                check("init_write_count", n_wr - wr0, v.exp_cnt);
                check("init_queue_drained", exp_wr.size(), 0);
            end
            K_OCW: begin
                @(negedge clk);
                ocw_req = 1'b1; ocw_a0 = v.a0; ocw_data = v.d;
                exp_wr.push_back({v.a0, v.d});
                @(negedge clk);
                ocw_req = 1'b0;
                check("ocw_setup_strobe", bus.wr_enable, 0);
                check("ocw_setup_oe", bus.data_oe, 1);
                check("ocw_setup_data", {bus.a0, bus.data_out}, {v.a0, v.d});
                repeat (P + 1) @(negedge clk);
                check("ocw_hold_strobe", bus.wr_enable, 0);
                check("ocw_hold_oe", bus.data_oe, 1);
                check("ocw_hold_data", bus.data_out, v.d);
                @(negedge clk);
                check("ocw_release_oe", bus.data_oe, 0);
                check("ocw_release_busy", busy, 0);
                check("ocw_write_count", n_wr - wr0, v.exp_cnt);
            end
            K_RD: begin
                rd_val = v.d;
                @(negedge clk);
                rd_req = 1'b1; rd_a0 = v.a0;
                exp_rd.push_back(v.d);
                @(negedge clk);
                rd_req = 1'b0;
                check("rd_strobe", {bus.rd_enable, bus.a0, bus.data_oe}, {1'b1, v.a0, 1'b0});
                for (int c = 0; c < 20; c++) begin
                    if (!busy) break;
                    @(negedge clk);
                end
                check("rd_done_idle", busy, 0);
                check("rd_count", n_rd - rd0, v.exp_cnt);
            end
            default: begin
                vec_val = v.d;
                exp_vec.push_back(v.d);
                auto_drop = 1'b1;
                @(negedge clk);
                bus.int_in = 1'b1;
                trace = '1;
                exp_trace = '1;
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    trace[i] = bus.inta_n;
                    if (i < P || (i >= P + G && i < 2 * P + G)) exp_trace[i] = 1'b0;
                end
                check("inta_trace", trace, exp_trace);
                check("inta_int_dropped", bus.int_in, 0);
                check("inta_vec_count", n_vec - vec0, v.exp_cnt);
                auto_drop = 1'b0;
            end
        endcase
    endtask

    initial begin
        int wr0, vec0, lows, busy_hi, rv0;

        tbl[0] = '{K_INIT, 8'h13, 8'h40, 8'h00, 8'h02, 1'b0, 8'h00, 3};
        tbl[1] = '{K_INIT, 8'h11, 8'h40, 8'h04, 8'h02, 1'b0, 8'h00, 4};
        tbl[2] = '{K_INIT, 8'h12, 8'h48, 8'h00, 8'h00, 1'b0, 8'h00, 2};
        tbl[3] = '{K_INIT, 8'h10, 8'h40, 8'h08, 8'h00, 1'b0, 8'h00, 3};
        tbl[4] = '{K_INIT, 8'h13, 8'h40, 8'h00, 8'h02, 1'b0, 8'h00, 3};
        tbl[5] = '{K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hF0, 1};
        tbl[6] = '{K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h20, 1};
        tbl[7] = '{K_RD,   8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hF0, 1};
        tbl[8] = '{K_RD,   8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 1};
        tbl[9] = '{K_INTA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h45, 1};

        bus.int_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_enable", bus.wr_enable, 0);
        check("rst_rd_enable", bus.rd_enable, 0);
        check("rst_inta_n", bus.inta_n, 1);
        check("rst_a0", bus.a0, 0);
        check("rst_data_oe", bus.data_oe, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_vector", vector, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_vector_valid", vector_valid, 0);
        check("rst_initialized", initialized, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // INT and OCW in the same IDLE cycle: INTA wins, OCW is lost.
        wr0 = n_wr; vec0 = n_vec;
        vec_val = 8'h77;
        exp_vec.push_back(8'h77);
        auto_drop = 1'b1;
        @(negedge clk);
        bus.int_in = 1'b1; ocw_req = 1'b1; ocw_a0 = 1'b1; ocw_data = 8'hAA;
        @(negedge clk);
        ocw_req = 1'b0;
        check("prio_inta_first", bus.inta_n, 0);
        repeat (10) @(negedge clk);
        check("prio_ocw_dropped", n_wr - wr0, 0);
        check("prio_vec_count", n_vec - vec0, 1);
        auto_drop = 1'b0;

        // Requests before init are ignored.
        do_reset();
        wr0 = n_wr; rv0 = n_rd;
        lows = 0; busy_hi = 0;
        bus.int_in = 1'b1; ocw_req = 1'b1; rd_req = 1'b1; ocw_data = 8'h55;
        @(negedge clk);
        ocw_req = 1'b0; rd_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            lows += int'(!bus.inta_n);
            busy_hi += int'(busy);
            @(negedge clk);
        end
        bus.int_in = 1'b0;
        check("preinit_no_inta", lows, 0);
        check("preinit_no_busy", busy_hi, 0);
        check("preinit_no_write", n_wr - wr0, 0);
        check("preinit_no_read", n_rd - rv0, 0);

        // Reset in the middle of a write pulse.
        run_vec(tbl[0]);
        @(negedge clk);
        ocw_req = 1'b1; ocw_a0 = 1'b1; ocw_data = 8'h3C;
        exp_wr.push_back({1'b1, 8'h3C});
        @(negedge clk);
        ocw_req = 1'b0;
        @(negedge clk);
        check("mid_wr_strobe_high", bus.wr_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_wr_rst_strobe", bus.wr_enable, 0);
        check("mid_wr_rst_oe", bus.data_oe, 0);
        check("mid_wr_rst_init", initialized, 0);
        check("mid_wr_rst_busy", busy, 0);
        exp_wr.delete();
        @(negedge clk);
        inta_falls = 0;
        rst_n = 1'b1;
        wr0 = n_wr; rv0 = n_rd; vec0 = n_vec; busy_hi = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            busy_hi += int'(busy);
        end
        check("mid_wr_no_resume", n_wr - wr0 + n_rd - rv0 + n_vec - vec0, 0);
        check("mid_wr_stays_idle", busy_hi, 0);

        // Reset in the middle of INTA2.
        run_vec(tbl[0]);
        vec_val = 8'h99;
        exp_vec.push_back(8'h99);
        auto_drop = 1'b0;
        @(negedge clk);
        bus.int_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (inta_falls >= 2) break;
        end
        check("mid_inta2_reached", inta_falls, 2);
        check("mid_inta2_low", bus.inta_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_inta2_rst_inta", bus.inta_n, 1);
        check("mid_inta2_rst_oe", bus.data_oe, 0);
        check("mid_inta2_rst_init", initialized, 0);
        exp_vec.delete();
        @(negedge clk);
        inta_falls = 0;
        rst_n = 1'b1;
        vec0 = n_vec; lows = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            lows += int'(!bus.inta_n);
        end
        bus.int_in = 1'b0;
        check("mid_inta2_no_vector", n_vec - vec0, 0);
        check("mid_inta2_no_new_inta", lows, 0);
        check("final_queues_empty", exp_wr.size() + exp_rd.size() + exp_vec.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
